// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: data + control bundles behind a
// valid/ready handshake, with synchronous flush and bubble insertion.
// SKID=1 adds a second entry so in_ready comes straight from a flop;
// SKID=0 keeps a single entry and forwards out_ready combinationally.
module pipe_stage_reg #(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 24,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter bit                SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   main_data, main_data_n;
  logic [CTRL_W-1:0]   main_ctrl, main_ctrl_n;
  logic                main_vld, main_vld_n;
  logic [DATA_W-1:0]   skid_data, skid_data_n;
  logic [CTRL_W-1:0]   skid_ctrl, skid_ctrl_n;
  logic                skid_vld, skid_vld_n;
  logic                accept, drain;

  assign accept = in_valid & in_ready;
  assign drain  = main_vld & out_ready;

  // Next-state and entry movement; flush overrides everything, including
  // a same-cycle accept (dropped) and stall.
  always_comb begin
    state_n     = state;
    main_data_n = main_data;
    main_ctrl_n = main_ctrl;
    main_vld_n  = main_vld;
    skid_data_n = skid_data;
    skid_ctrl_n = skid_ctrl;
    skid_vld_n  = skid_vld;
    if (flush) begin
      state_n     = EMPTY;
      main_vld_n  = 1'b0;
      main_ctrl_n = CTRL_BUBBLE;
      skid_vld_n  = 1'b0;
      skid_ctrl_n = CTRL_BUBBLE;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data_n = in_data;
            main_ctrl_n = in_ctrl;
            main_vld_n  = 1'b1;
            state_n     = ONE;
          end
        end
        ONE: begin
          if (drain && accept) begin
            main_data_n = in_data;
            main_ctrl_n = in_ctrl;
          end else if (drain) begin
            // Bubble: control forced safe, data left as-is.
            main_ctrl_n = CTRL_BUBBLE;
            main_vld_n  = 1'b0;
            state_n     = EMPTY;
          end else if (accept && SKID) begin
            skid_data_n = in_data;
            skid_ctrl_n = in_ctrl;
            skid_vld_n  = 1'b1;
            state_n     = FULL;
          end
        end
        FULL: begin
          // in_ready is low here, so only a drain can move anything.
          if (drain) begin
            main_data_n = skid_data;
            main_ctrl_n = skid_ctrl;
            skid_vld_n  = 1'b0;
            skid_ctrl_n = CTRL_BUBBLE;
            state_n     = ONE;
          end
        end
        default: begin
          state_n     = EMPTY;
          main_vld_n  = 1'b0;
          main_ctrl_n = CTRL_BUBBLE;
          skid_vld_n  = 1'b0;
        end
      endcase
    end
  end

  // Entry registers; skid regs get defined values so nothing unknown leaks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= CTRL_BUBBLE;
      main_vld  <= 1'b0;
      skid_data <= '0;
      skid_ctrl <= CTRL_BUBBLE;
      skid_vld  <= 1'b0;
    end else begin
      state     <= state_n;
      main_data <= main_data_n;
      main_ctrl <= main_ctrl_n;
      main_vld  <= main_vld_n;
      skid_data <= skid_data_n;
      skid_ctrl <= skid_ctrl_n;
      skid_vld  <= skid_vld_n;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic rdy_q;
      // Registered ready: mirrors "skid slot free" for the coming cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_q <= 1'b1;
        else      rdy_q <= ~skid_vld_n;
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign in_ready = ~main_vld | out_ready;
    end
  endgenerate

  assign out_valid = main_vld;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occ       = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus;
// each is checked every cycle against a queue model, plus directed literals.
module tb_pipe_stage_reg;
  localparam int DW = 64;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_ready = 1'b0;

  logic          rdy1, vld1, rdy0, vld0;
  logic [DW-1:0] dat1, dat0;
  logic [CW-1:0] ctl1, ctl0;
  logic [1:0]    occ1, occ0;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE('0), .SKID(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(vld1), .out_ready(out_ready),
    .out_data(dat1), .out_ctrl(ctl1), .occ(occ1));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE('0), .SKID(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(vld0), .out_ready(out_ready),
    .out_data(dat0), .out_ctrl(ctl0), .occ(occ0));

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [DW-1:0] d; logic [CW-1:0] c; } ent_t;
  ent_t          q1[$];
  ent_t          q0[$];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last0 = '0;

  function automatic bit mrdy1();
    return q1.size() < 2;
  endfunction
  function automatic bit mrdy0();
    return (q0.size() == 0) || out_ready;
  endfunction

  // Reset drops every held entry at once.
  always @(negedge rst) begin
    q1.delete(); q0.delete();
    last1 = '0; last0 = '0;
  end

  // One transfer step per edge, straight from the handshake rules.
  always @(posedge clk) begin
    if (rst) begin
      bit a1, a0, d1, d0;
      a1 = in_valid && mrdy1();
      a0 = in_valid && mrdy0();
      d1 = (q1.size() > 0) && out_ready;
      d0 = (q0.size() > 0) && out_ready;
      if (flush) begin
        q1.delete(); q0.delete();
      end else begin
        if (d1) void'(q1.pop_front());
        if (a1) q1.push_back('{in_data, in_ctrl});
        if (d0) void'(q0.pop_front());
        if (a0) q0.push_back('{in_data, in_ctrl});
      end
      if (q1.size() > 0) last1 = q1[0].d;
      if (q0.size() > 0) last0 = q0[0].d;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      chk("m1_valid", DW'(vld1), DW'(q1.size() > 0));
      chk("m1_ctrl",  DW'(ctl1), (q1.size() > 0) ? DW'(q1[0].c) : '0);
      chk("m1_data",  dat1, last1);
      chk("m1_occ",   DW'(occ1), DW'(q1.size()));
      chk("m1_ready", DW'(rdy1), DW'(mrdy1()));
      chk("m0_valid", DW'(vld0), DW'(q0.size() > 0));
      chk("m0_ctrl",  DW'(ctl0), (q0.size() > 0) ? DW'(q0[0].c) : '0);
      chk("m0_data",  dat0, last0);
      chk("m0_occ",   DW'(occ0), DW'(q0.size()));
      chk("m0_ready", DW'(rdy0), DW'(mrdy0()));
    end
  end

  // Drive one cycle of stimulus at the falling edge, then settle.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input bit ordy, input bit fl);
    @(negedge clk);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
    #3;
  endtask

  initial begin
    rst = 1'b0;
    chk_on = 1'b1;
    // Reset held with a transfer offered.
    cyc(1, 64'h1234, 24'h5, 1, 0);
    cyc(1, 64'h1234, 24'h5, 1, 0);
    chk("rst_valid", DW'(vld1), '0);
    chk("rst_ctrl",  DW'(ctl1), '0);
    chk("rst_occ",   DW'(occ1), '0);
    @(negedge clk); rst = 1'b1;
    #3;
    chk("rel_ready", DW'(rdy1), 64'd1);
    cyc(0, '0, '0, 0, 0);
    chk("first_valid", DW'(vld1), 64'd1);
    chk("first_data",  dat1, 64'h1234);

    // Stall with A1 held: A2 goes to skid, A3 waits upstream.
    cyc(1, 64'hA2, 24'h2, 0, 0);
    cyc(1, 64'hA3, 24'h3, 0, 0);
    chk("stall_occ",   DW'(occ1), 64'd2);
    chk("stall_ready", DW'(rdy1), 64'd0);
    chk("stall_data",  dat1, 64'h1234);
    cyc(1, 64'hA3, 24'h3, 0, 0);
    chk("stall_hold",  dat1, 64'h1234);
    cyc(1, 64'hA3, 24'h3, 1, 0);
    cyc(1, 64'hA3, 24'h3, 1, 0);
    chk("rel_a2",   dat1, 64'hA2);
    cyc(0, '0, '0, 0, 0);
    chk("rel_a3",   dat1, 64'hA3);

    // Fill then flush while FULL with A4 offered.
    cyc(1, 64'hB0, 24'h7, 0, 0);
    cyc(1, 64'hA4, 24'h4, 0, 1);
    chk("pre_flush_occ", DW'(occ1), 64'd2);
    cyc(0, '0, '0, 0, 0);
    chk("flush_valid", DW'(vld1), 64'd0);
    chk("flush_ctrl",  DW'(ctl1), 64'd0);
    chk("flush_occ",   DW'(occ1), 64'd0);

    // Drain to empty after an all-ones control word.
    cyc(1, 64'hD00D, 24'hFFFFFF, 0, 0);
    cyc(0, '0, '0, 1, 0);
    chk("drain_ctrl_full", DW'(ctl1), 64'hFFFFFF);
    cyc(0, '0, '0, 1, 0);
    chk("drain_bubble", DW'(ctl1), 64'd0);
    chk("drain_data",   dat1, 64'hD00D);

    // SKID=0: ready follows out_ready in the same cycle.
    cyc(1, 64'hE0, 24'h1, 0, 0);
    cyc(1, 64'hF0, 24'h2, 0, 0);
    chk("s0_stall_ready", DW'(rdy0), 64'd0);
    cyc(1, 64'hF0, 24'h2, 1, 0);
    chk("s0_pass_ready", DW'(rdy0), 64'd1);
    cyc(0, '0, '0, 1, 0);
    chk("s0_b2b_data", dat0, 64'hF0);
    chk("s0_b2b_occ",  DW'(occ0), 64'd1);

    // Randomized traffic with occasional flush and mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      in_ctrl   = CW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      #3;
    end
    @(negedge clk); rst = 1'b1;
    #4;
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
